// File: rtl/videogen_sched_if.sv
// Pattern request handshake between a controller (master) and videogen_sched (slave).
// Latency: n/a (wires only).
// Backpressure: req_ready low stalls the master; a beat transfers on req_valid & req_ready.
// Signals: req_valid / req_pattern[2:0] from master, req_ready from slave.
interface videogen_sched_if;
  logic       req_valid;
  logic [2:0] req_pattern;
  logic       req_ready;

  modport master (output req_valid, output req_pattern, input req_ready);
  modport slave  (input req_valid, input req_pattern, output req_ready);
endinterface

// File: rtl/videogen_sched.sv
// Test-pattern scheduler: applies requested or auto-cycled patterns at frame starts, then mutes.
// Latency: all effects visible one clk27 after the request/frame-start cycle; outputs registered.
// Backpressure: req_ready is high only in RUN; PENDING and MUTE stall new requests.
// Ports: clk27, reset_n (async, active-low), vsync_in (neg. polarity), auto_en,
//        req (slave handshake), pattern_sel[2:0], mute, switch_pulse, err_pulse, frame_cnt[15:0].
module videogen_sched #(
  parameter int NUM_PATTERNS    = 4,
  parameter int DEFAULT_PATTERN = 0,
  parameter int MUTE_FRAMES     = 2,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic               clk27,
  input  logic               reset_n,
  input  logic               vsync_in,
  input  logic               auto_en,
  videogen_sched_if.slave    req,
  output logic [2:0]         pattern_sel,
  output logic               mute,
  output logic               switch_pulse,
  output logic               err_pulse,
  output logic [15:0]        frame_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_PENDING, ST_MUTE} state_t;

  localparam logic [3:0] NUM_P     = 4'(NUM_PATTERNS);
  localparam logic [2:0] LAST_P    = 3'(NUM_PATTERNS - 1);
  localparam logic [2:0] DEF_P     = 3'(DEFAULT_PATTERN);
  localparam logic [7:0] AUTO_LAST = 8'(AUTO_FRAMES - 1);
  localparam logic [7:0] MUTE_INIT = 8'(MUTE_FRAMES);
  localparam bit         MUTE_EN   = (MUTE_FRAMES > 0);

  state_t      state_q, state_d;
  logic        vs_d_q, vs_d_d;
  logic [2:0]  pattern_sel_q, pattern_sel_d;
  logic [2:0]  pend_pat_q, pend_pat_d;
  logic        mute_q, mute_d;
  logic        switch_pulse_q, switch_pulse_d;
  logic        err_pulse_q, err_pulse_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  auto_cnt_q, auto_cnt_d;
  logic [7:0]  mute_cnt_q, mute_cnt_d;

  logic        fs;
  logic        do_switch;
  logic [2:0]  sw_pat;
  logic [2:0]  next_pat;

  // Frame start is the VSYNC falling edge (sync is active-low).
  assign fs = vs_d_q & ~vsync_in;

  // Wrap to 0 past the last valid code; also recovers if the default is out of range.
  assign next_pat = (pattern_sel_q >= LAST_P) ? 3'd0 : pattern_sel_q + 3'd1;

  assign req.req_ready = (state_q == ST_RUN);

  always_comb begin
    state_d        = state_q;
    vs_d_d         = vsync_in;
    pattern_sel_d  = pattern_sel_q;
    pend_pat_d     = pend_pat_q;
    mute_d         = mute_q;
    switch_pulse_d = 1'b0;
    err_pulse_d    = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    auto_cnt_d     = auto_cnt_q;
    mute_cnt_d     = mute_cnt_q;
    do_switch      = 1'b0;
    sw_pat         = pend_pat_q;

    if (fs) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    unique case (state_q)
      ST_RUN: begin
        if (req.req_valid) begin
          // Any handshake (valid or not) takes priority over auto cycling this cycle.
          if ({1'b0, req.req_pattern} < NUM_P) begin
            pend_pat_d = req.req_pattern;
            auto_cnt_d = 8'd0;
            state_d    = ST_PENDING;
          end else begin
            err_pulse_d = 1'b1;
          end
        end else if (auto_en) begin
          if (fs) begin
            if (auto_cnt_q == AUTO_LAST) begin
              do_switch  = 1'b1;
              sw_pat     = next_pat;
              auto_cnt_d = 8'd0;
            end else begin
              auto_cnt_d = auto_cnt_q + 8'd1;
            end
          end
        end else begin
          auto_cnt_d = 8'd0;
        end
      end

      ST_PENDING: begin
        // The accept cycle moved us here, so an fs in that same cycle was not seen here.
        if (fs) begin
          do_switch = 1'b1;
          sw_pat    = pend_pat_q;
        end
      end

      ST_MUTE: begin
        auto_cnt_d = 8'd0;
        if (fs) begin
          mute_cnt_d = mute_cnt_q - 8'd1;
          // Leaving on the count-of-one frame start gives exactly MUTE_FRAMES muted frames.
          if (mute_cnt_q == 8'd1) begin
            mute_d  = 1'b0;
            state_d = ST_RUN;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (do_switch) begin
      pattern_sel_d  = sw_pat;
      switch_pulse_d = 1'b1;
      if (MUTE_EN) begin
        mute_d     = 1'b1;
        mute_cnt_d = MUTE_INIT;
        state_d    = ST_MUTE;
      end else begin
        mute_d  = 1'b0;
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_RUN;
      vs_d_q         <= 1'b1;
      pattern_sel_q  <= DEF_P;
      pend_pat_q     <= 3'd0;
      mute_q         <= 1'b0;
      switch_pulse_q <= 1'b0;
      err_pulse_q    <= 1'b0;
      frame_cnt_q    <= 16'd0;
      auto_cnt_q     <= 8'd0;
      mute_cnt_q     <= 8'd0;
    end else begin
      state_q        <= state_d;
      vs_d_q         <= vs_d_d;
      pattern_sel_q  <= pattern_sel_d;
      pend_pat_q     <= pend_pat_d;
      mute_q         <= mute_d;
      switch_pulse_q <= switch_pulse_d;
      err_pulse_q    <= err_pulse_d;
      frame_cnt_q    <= frame_cnt_d;
      auto_cnt_q     <= auto_cnt_d;
      mute_cnt_q     <= mute_cnt_d;
    end
  end

  assign pattern_sel  = pattern_sel_q;
  assign mute         = mute_q;
  assign switch_pulse = switch_pulse_q;
  assign err_pulse    = err_pulse_q;
  assign frame_cnt    = frame_cnt_q;

endmodule
